// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: program load port in, instruction/status out to the CU side.
interface instr_fetch_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
);
  logic                   start;
  logic                   load_en;
  logic [PC_BITS-1:0]     load_addr;
  logic [INSTR_WIDTH-1:0] load_data;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_BITS-1:0]     pc;
  logic                   busy;
  logic                   halted;

  modport master (output start, load_en, load_addr, load_data,
                  input  instr, pc, busy, halted);
  modport slave  (input  start, load_en, load_addr, load_data,
                  output instr, pc, busy, halted);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: loadable memory, PC and a hold counter that paces each
// instruction for as many cycles as the CU spends on its class.
module instr_fetch #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  bus
);
  localparam int DEPTH = 1 << PC_BITS;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [2:0]             hold_q, hold_d;
  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
  logic [INSTR_WIDTH-1:0] mem_d [DEPTH];

  logic [INSTR_WIDTH-1:0] word;
  logic [1:0]             cls;
  logic [PC_BITS-1:0]     pc_nxt;

  function automatic logic [2:0] hold_len(input logic [1:0] c);
    case (c)
      2'b01:   hold_len = 3'd3;
      2'b10:   hold_len = 3'd4;
      2'b11:   hold_len = 3'd3;
      default: hold_len = 3'd0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    mem_d   = mem_q;
    word    = '0;
    cls     = 2'b00;
    pc_nxt  = pc_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.load_en) mem_d[bus.load_addr] = bus.load_data;
        if (bus.start) begin
          // Read after the same-cycle write so a load to address 0 is issued.
          word    = mem_d[0];
          cls     = word[INSTR_WIDTH-1:INSTR_WIDTH-2];
          instr_d = word;
          pc_d    = '0;
          // First issue holds H+1 cycles: count H down to 0 inclusive.
          hold_d  = hold_len(cls);
          state_d = (cls == 2'b00) ? HALT : RUN;
        end
      end
      RUN: begin
        if (hold_q == 3'd0) begin
          word    = mem_q[pc_nxt];
          cls     = word[INSTR_WIDTH-1:INSTR_WIDTH-2];
          instr_d = word;
          pc_d    = pc_nxt;
          if (cls == 2'b00) begin
            hold_d  = 3'd0;
            state_d = HALT;
          end else begin
            hold_d  = hold_len(cls) - 3'd1;
          end
        end else begin
          hold_d = hold_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      hold_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.instr  = instr_q;
  assign bus.pc     = pc_q;
  assign bus.busy   = (state_q == RUN);
  assign bus.halted = (state_q == HALT);
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a program-level model expands each start
// into a per-cycle expected trace; a monitor compares at each falling edge.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  instr_fetch_if #(.INSTR_WIDTH(20), .PC_BITS(5)) bus ();

  instr_fetch #(.INSTR_WIDTH(20), .PC_BITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    int          stamp;
    logic [19:0] instr;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;
  } exp_t;

  exp_t        q[$];
  logic [19:0] mem [32];

  task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("trace{instr,pc,busy,halted}",
          {bus.instr, bus.pc, bus.busy, bus.halted},
          {e.instr, e.pc, e.busy, e.halted});
    end
  end

  function automatic int hlen(input logic [1:0] c);
    return (c == 2'b10) ? 4 : 3;
  endfunction

  // Program-level model: walk memory from 0, each word shown for its class
  // duration (one extra on the first), stop forever on a class-00 word.
  task automatic gen_trace(input int stamp, input int len);
    int p = 0;
    int t = 0;
    bit first = 1;
    while (t < len) begin
      logic [19:0] w;
      w = mem[p];
      if (w[19:18] == 2'b00) begin
        q.push_back('{stamp + t, w, 5'(p), 1'b0, 1'b1});
        t++;
      end else begin
        int h;
        h = hlen(w[19:18]) + (first ? 1 : 0);
        first = 0;
        for (int k = 0; k < h && t < len; k++) begin
          q.push_back('{stamp + t, w, 5'(p), 1'b1, 1'b0});
          t++;
        end
        p = (p + 1) % 32;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    #1;
    chk("reset_async", {bus.instr, bus.pc, bus.busy, bus.halted}, 27'd0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic load(input int a, input logic [19:0] d);
    @(posedge clk); #1;
    bus.load_en = 1'b1; bus.load_addr = 5'(a); bus.load_data = d;
    mem[a] = d;
    @(posedge clk); #1;
    bus.load_en = 1'b0;
  endtask

  // Returns at E0+1 (+#1); trace for len cycles is already queued.
  task automatic issue_start(input int len);
    @(posedge clk); #1;
    bus.start = 1'b1;
    gen_trace(cyc + 1, len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.load_en = 1'b0;
  endtask

  task automatic pulse_ignored(input int a, input logic [19:0] d);
    bus.load_en = 1'b1; bus.load_addr = 5'(a); bus.load_data = d;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.load_en = 1'b0; bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset values, then start on an empty memory halts at pc 0.
    do_reset();
    issue_start(6);
    repeat (6) @(posedge clk);

    // Mixed classes: 4 + 4 + 3 then halt; start/load ignored in HALT.
    do_reset();
    load(0, 20'h41230); load(1, 20'h91050); load(2, 20'hC2080); load(3, 20'h00000);
    issue_start(24);
    repeat (15) @(posedge clk); #1;
    pulse_ignored(3, 20'h41230);
    repeat (10) @(posedge clk);

    // Wrap-around with ignored load/start during the first hold.
    do_reset();
    for (int i = 0; i < 32; i++) load(i, 20'h40000);
    issue_start(120);
    pulse_ignored(1, 20'h00000);
    repeat (120) @(posedge clk);

    // Simultaneous load and start at address 0.
    do_reset();
    @(posedge clk); #1;
    bus.load_en = 1'b1; bus.load_addr = '0; bus.load_data = 20'h85550;
    mem[0] = 20'h85550;
    bus.start = 1'b1;
    gen_trace(cyc + 1, 10);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.load_en = 1'b0;
    repeat (10) @(posedge clk);

    // Reset during the hold of mem[1]; memory must come back cleared.
    do_reset();
    load(0, 20'h41111); load(1, 20'h92222); load(2, 20'hC3333);
    issue_start(20);
    repeat (5) @(posedge clk);
    do_reset();
    issue_start(6);
    repeat (6) @(posedge clk);

    // Random programs, halt word carries random low bits.
    for (int it = 0; it < 6; it++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++)
        load(i, {2'($urandom_range(1, 3)), 18'($urandom)});
      load(n, {2'b00, 18'($urandom)});
      issue_start(5 * n + 8);
      repeat (5 * n + 8) @(posedge clk);
    end

    @(negedge clk); #1;
    chk("scoreboard_drained", 27'(q.size()), 27'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the control unit. It holds a small loadable instruction memory, a program counter and a pacing counter, and it drives the CU's `instr` input. Each instruction is held stable for exactly the number of cycles the CU needs to walk its state sequence for that instruction class, and then the next one is presented. Fetching stops when a halt word (class `00`) is reached.

## Interface
Parameters:
- `INSTR_WIDTH`, 20, instruction width; class field is `[INSTR_WIDTH-1:INSTR_WIDTH-2]`.
- `PC_BITS`, 5, address width; the memory depth is 2^PC_BITS (32) words.

Ports:
- `clk`, input, 1, single clock; all state changes on the rising edge.
- `rst`, input, 1, asynchronous, active-low reset.
- `start`, input, 1, single-cycle pulse; begins execution at address 0 when the block is in IDLE.
- `load_en`, input, 1, write strobe for the instruction memory.
- `load_addr`, input, PC_BITS, memory write address.
- `load_data`, input, INSTR_WIDTH, memory write data.
- `instr`, output, INSTR_WIDTH, registered instruction to the CU.
- `pc`, output, PC_BITS, address of the word currently on `instr`.
- `busy`, output, 1, high while instructions are being issued.
- `halted`, output, 1, high once a halt word has been fetched.

## Operation
- States: IDLE, RUN, HALT.
- Reset (async, `rst`=0): state = IDLE; `instr` = 0; `pc` = 0; `busy` = 0; `halted` = 0; hold counter = 0; all memory words cleared to 0.
- Memory writes:
  - A write occurs at the clock edge when `load_en`=1 and state = IDLE.
  - Writes are ignored in RUN and HALT.
- IDLE + `start`=1:
  - Register `instr` ← mem[0] and `pc` ← 0.
  - If the class of mem[0] is `00`, go to HALT.
  - Otherwise go to RUN with `busy`=1.
- Hold length `H(class)` per instruction class:
  - `01` (std_op) = 3 cycles.
  - `10` (loadR) = 4 cycles.
  - `11` (storeR) = 3 cycles.
- The first instruction issued after IDLE is held `H`+1 cycles, because the CU needs one extra cycle to leave its RESET state.
- RUN:
  - The hold counter is loaded at issue and decrements every cycle.
  - When it expires: `pc` ← `pc`+1 (mod 2^PC_BITS, so 31 wraps to 0) and `instr` ← mem[`pc`+1].
  - If the new word's class is `00`, go to HALT at that same edge.
- HALT:
  - `instr` holds the halt word and `pc` holds its address.
  - `busy`=0, `halted`=1.
  - `start` and `load_en` are ignored; only `rst` leaves HALT.
- `start` in RUN or HALT is ignored.
- `load_en` and `start` in the same IDLE cycle: the write commits at that edge and the issue reads memory after the write. If `load_addr`=0, the new data is what gets issued.
- Reset asserted mid-run: immediate return to reset values and memory cleared. The CU is reset by the same signal.

## Timing
- `start` sampled at edge E0: the new `instr`, `pc` and `busy` values are visible just after E0.
- Output changes:
  - The first instruction changes at E0+H+1.
  - Each later instruction changes H edges after its own issue edge.
- Memory read is combinational from the array into the `instr` register, so there is no extra pipeline cycle.
- `halted` rises at the same edge that presents the halt word, and `busy` falls at that same edge.
- A program of N non-halt instructions followed by a halt presents the halt word at edge E0 + 1 + ΣH.

## Test plan
- **Reset values:** assert `rst`=0 mid-cycle, then release. Required: `instr`=0, `pc`=0, `busy`=0, `halted`=0 immediately (asynchronous). Issuing `start` with an empty memory then gives `halted`=1 and `pc`=0.
- **Mixed classes:**
  - Load mem[0]=20'h41230 (std_op), mem[1]=20'h91050 (loadR), mem[2]=20'hC2080 (storeR), mem[3]=0, then pulse `start`.
  - Required: `instr` holds 41230 for 4 cycles, 91050 for 4, C2080 for 3.
  - Then `instr`=0, `pc`=3, `halted`=1, `busy`=0, and everything stays frozen.
- **Wrap-around:** fill all 32 words with 20'h40000 and start. Required: `pc` counts 0..31, then 0, 1, …, with `busy` staying 1. The first hold is 4 cycles and all later holds are 3.
- **Ignored inputs:** in RUN, pulse `load_en` with addr 1, data 20'h00000, and pulse `start`. Required: mem[1] unchanged, `pc` sequence unchanged, no restart.
- **Simultaneous load and start:** in IDLE, assert `load_en` (addr 0, data 20'h85550) and `start` in the same cycle. Required: `instr`=20'h85550 after that edge, held 5 cycles.
- **Reset mid-run:** assert `rst` during the hold of mem[1]. Required: immediate reset values. After release and a new `start`, the block halts at `pc`=0 because memory was cleared.
